button_reader: RTL

- Input-side counterpart to the LED chaser: samples NUM_BTN raw pushbutton/switch pins, synchronises and debounces them.
- Emits a clean level, single-cycle press/release/hold pulses, and sticky press flags for the control logic.
- Runs on the fabric clock, with a free-running tick prescaler shared by all channels.

---
 rtl/btn_pkg.sv | 17 +
 rtl/button_debounce_ch.sv | 143 ++++++++++++++
 rtl/button_reader.sv | 63 ++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button reader: channel FSM encoding and default parameter set.
package btn_pkg;

   // Per-channel debounce FSM encoding
   localparam logic [1:0] ST_OFF     = 2'd0;
   localparam logic [1:0] ST_CHK_ON  = 2'd1;
   localparam logic [1:0] ST_ON      = 2'd2;
   localparam logic [1:0] ST_CHK_OFF = 2'd3;

   // Default build: 6 buttons, 1 ms tick at 50 MHz, 20 ms debounce, 1 s hold
   localparam int DEF_NUM_BTN        = 6;
   localparam int DEF_TICK_DIV       = 50000;
   localparam int DEF_DEBOUNCE_TICKS = 20;
   localparam int DEF_HOLD_TICKS     = 1000;
   localparam int DEF_ACTIVE_LOW     = 0;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchroniser, polarity fix-up, debounce FSM with
// tick-based debounce and hold counters, and a sticky press flag.
module button_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
   parameter int ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   input  logic latch_clr,
   input  logic tick,
   output logic btn_state,
   output logic btn_press,
   output logic btn_release,
   output logic btn_hold,
   output logic press_latched
);

   localparam int DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);
   localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   // Released pin level; the synchroniser idles here so s reads 0 out of reset
   localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

   logic [1:0]        r_sync;
   logic [1:0]        r_fsm;
   logic [DEB_W-1:0]  r_deb_cnt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_state;
   logic              r_press;
   logic              r_release;
   logic              r_hold;
   logic              r_latched;
   logic              w_s;

   // Normalised level, 1 = pressed regardless of pin polarity
   assign w_s = r_sync[1] ^ PIN_IDLE;

   // Two-flop synchroniser for the asynchronous pin
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= {2{PIN_IDLE}};
      end else begin
         r_sync <= {r_sync[0], btn_in};
      end
   end

   // Debounce FSM; pulses are cleared every cycle unless an event fires
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm      <= ST_OFF;
         r_deb_cnt  <= '0;
         r_hold_cnt <= '0;
         r_state    <= 1'b0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_hold     <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_hold    <= 1'b0;
         case (r_fsm)
            ST_OFF: begin
               if (w_s) begin
                  r_fsm     <= ST_CHK_ON;
                  r_deb_cnt <= '0;
               end
            end
            ST_CHK_ON: begin
               if (!w_s) begin
                  r_fsm <= ST_OFF;
               end else if (tick) begin
                  if (r_deb_cnt == DEB_LAST) begin
                     r_fsm      <= ST_ON;
                     r_state    <= 1'b1;
                     r_press    <= 1'b1;
                     r_hold_cnt <= '0;
                  end else begin
                     r_deb_cnt <= r_deb_cnt + DEB_ONE;
                  end
               end
            end
            ST_ON: begin
               // Hold counter saturates so the hold pulse fires only once per press
               if (tick && (r_hold_cnt != HOLD_MAX)) begin
                  r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                  if (r_hold_cnt == HOLD_LAST) begin
                     r_hold <= 1'b1;
                  end
               end
               if (!w_s) begin
                  r_fsm     <= ST_CHK_OFF;
                  r_deb_cnt <= '0;
               end
            end
            ST_CHK_OFF: begin
               // Hold counter is frozen here so a bounce does not restart the hold
               if (w_s) begin
                  r_fsm <= ST_ON;
               end else if (tick) begin
                  if (r_deb_cnt == DEB_LAST) begin
                     r_fsm     <= ST_OFF;
                     r_state   <= 1'b0;
                     r_release <= 1'b1;
                  end else begin
                     r_deb_cnt <= r_deb_cnt + DEB_ONE;
                  end
               end
            end
            default: begin
               r_fsm <= ST_OFF;
            end
         endcase
      end
   end

   // Sticky press flag; a press pulse overrides a coincident clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_latched <= 1'b0;
      end else if (r_press) begin
         r_latched <= 1'b1;
      end else if (latch_clr) begin
         r_latched <= 1'b0;
      end
   end

   assign btn_state     = r_state;
   assign btn_press     = r_press;
   assign btn_release   = r_release;
   assign btn_hold      = r_hold;
   assign press_latched = r_latched;

endmodule

// File: rtl/button_reader.sv
// Button reader top: shared debounce-tick prescaler fanned out to NUM_BTN
// independent debounce channels.
module button_reader
   import btn_pkg::*;
#(
   parameter int NUM_BTN        = DEF_NUM_BTN,
   parameter int TICK_DIV       = DEF_TICK_DIV,
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
   parameter int ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_in,
   input  logic [NUM_BTN-1:0] latch_clr,
   output logic [NUM_BTN-1:0] btn_state,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_hold,
   output logic [NUM_BTN-1:0] press_latched
);

   localparam int TICK_W = $clog2(TICK_DIV);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

   logic [TICK_W-1:0] r_tick_cnt;
   logic              w_tick;

   assign w_tick = (r_tick_cnt == TICK_LAST);

   // Free-running prescaler, wraps after TICK_DIV cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + TICK_ONE;
      end
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      button_debounce_ch #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .HOLD_TICKS     (HOLD_TICKS),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .btn_in        (btn_in[g]),
         .latch_clr     (latch_clr[g]),
         .tick          (w_tick),
         .btn_state     (btn_state[g]),
         .btn_press     (btn_press[g]),
         .btn_release   (btn_release[g]),
         .btn_hold      (btn_hold[g]),
         .press_latched (press_latched[g])
      );
   end

endmodule
